// File: rtl/ac_pkg.sv
// ---------------------------------------------------------------------------
// ac_pkg: shared types and default sizing for the access-control frame
// sequencer (ac_frame_ctrl) and its 2-D beat counter (ac_xy_counter).
// ---------------------------------------------------------------------------
package ac_pkg;

    // Default width of source geometry fields and input-side counters.
    localparam int unsigned CNT_W_DEF      = 16;
    // Default log2 of the per-axis up-scale factor (2 -> 4x per axis).
    localparam int unsigned SCALE_LOG2_DEF = 2;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : ac_pkg

// File: rtl/ac_xy_counter.sv
// ---------------------------------------------------------------------------
// ac_xy_counter: 2-D raster position counter. x advances on inc and wraps at
// x_max back to 0, advancing y. clr has priority over inc.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             return to (0,0)
//   inc             advance by one beat
//   x_max, y_max    last column / last row index (inclusive)
//   x, y            current position
//   x_end           x is on the last column
//   last            position is the final beat of the raster
// ---------------------------------------------------------------------------
module ac_xy_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] x_max,
    input  logic [WIDTH-1:0] y_max,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             x_end,
    output logic             last
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;

    // Position decode.
    always_comb begin
        x_end = (x_q == x_max);
        last  = x_end && (y_q == y_max);
    end

    // Next position.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (inc) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_q + WIDTH'(1);
            end else begin
                x_d = x_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule : ac_xy_counter

// File: rtl/ac_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ac_frame_ctrl: frame sequencer between the access-control stream ports and
// the up-sampling core. Latches source geometry on start, gates input beat
// acceptance, counts input and output beats, generates output tlast/tuser,
// raises a level done interrupt and flags framing errors.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_start                start pulse (honoured in IDLE only)
//   cfg_width, cfg_height    source geometry
//   irq_clr                  clears interrupt_updone, returns to IDLE
//   in_en                    input handshake permit
//   in_fire, in_tlast        accepted input beat and its tlast
//   out_fire                 accepted output beat
//   out_tlast, out_tuser     output framing for the current beat
//   busy                     frame in progress
//   interrupt_updone         frame complete (level)
//   err_tlast, err_cfg       sticky error flags
// ---------------------------------------------------------------------------
module ac_frame_ctrl
    import ac_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned SCALE_LOG2 = SCALE_LOG2_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_height,
    input  logic             irq_clr,
    output logic             in_en,
    input  logic             in_fire,
    input  logic             in_tlast,
    input  logic             out_fire,
    output logic             out_tlast,
    output logic             out_tuser,
    output logic             busy,
    output logic             interrupt_updone,
    output logic             err_tlast,
    output logic             err_cfg
);

    localparam int unsigned OUT_W = CNT_W + SCALE_LOG2;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic             in_done_q, in_done_d;
    logic             out_done_q, out_done_d;
    logic             err_tlast_q, err_tlast_d;
    logic             err_cfg_q, err_cfg_d;

    logic             cfg_ok;
    logic             start_acc;
    logic             in_acc;
    logic             out_acc;
    logic [CNT_W-1:0] in_x_max, in_y_max;
    logic [OUT_W-1:0] out_x_max, out_y_max;

    // Input position is only needed through its end/last decodes.
    logic [CNT_W-1:0] in_x_unused, in_y_unused;
    logic             in_x_end, in_last;
    logic [OUT_W-1:0] out_x, out_y;
    logic             out_x_end, out_last;

    // Qualified events and counter limits. Output limits are widened before
    // the shift so a full-scale width cannot overflow.
    always_comb begin
        cfg_ok    = (cfg_width != '0) && (cfg_height != '0);
        start_acc = (state_q == IDLE) && cfg_start && cfg_ok;
        in_acc    = (state_q == RUN) && in_fire && !in_done_q;
        out_acc   = (state_q == RUN) && out_fire && !out_done_q;
        in_x_max  = w_q - CNT_W'(1);
        in_y_max  = h_q - CNT_W'(1);
        out_x_max = (OUT_W'(w_q) << SCALE_LOG2) - OUT_W'(1);
        out_y_max = (OUT_W'(h_q) << SCALE_LOG2) - OUT_W'(1);
    end

    ac_xy_counter #(
        .WIDTH (CNT_W)
    ) u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .inc   (in_acc),
        .x_max (in_x_max),
        .y_max (in_y_max),
        .x     (in_x_unused),
        .y     (in_y_unused),
        .x_end (in_x_end),
        .last  (in_last)
    );

    ac_xy_counter #(
        .WIDTH (OUT_W)
    ) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .inc   (out_acc),
        .x_max (out_x_max),
        .y_max (out_y_max),
        .x     (out_x),
        .y     (out_y),
        .x_end (out_x_end),
        .last  (out_last)
    );

    // Next-state, geometry latch, done and error flags.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        in_done_d   = in_done_q;
        out_done_d  = out_done_q;
        err_tlast_d = err_tlast_q;
        err_cfg_d   = err_cfg_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_ok) begin
                        w_d         = cfg_width;
                        h_d         = cfg_height;
                        in_done_d   = 1'b0;
                        out_done_d  = 1'b0;
                        err_tlast_d = 1'b0;
                        err_cfg_d   = 1'b0;
                        state_d     = RUN;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (in_acc) begin
                    // Flag tlast disagreement; the counter is not realigned.
                    if (in_tlast != in_x_end) begin
                        err_tlast_d = 1'b1;
                    end
                    if (in_last) begin
                        in_done_d = 1'b1;
                    end
                end
                if (out_acc && out_last) begin
                    out_done_d = 1'b1;
                end
                // Next-cycle flags so both finishing together still leaves.
                if (in_done_d && out_done_d) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (irq_clr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            in_done_q   <= 1'b0;
            out_done_q  <= 1'b0;
            err_tlast_q <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            h_q         <= h_d;
            in_done_q   <= in_done_d;
            out_done_q  <= out_done_d;
            err_tlast_q <= err_tlast_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    // Status and framing outputs decoded from registered state.
    always_comb begin
        busy             = (state_q == RUN);
        interrupt_updone = (state_q == DONE);
        in_en            = busy && !in_done_q;
        out_tlast        = busy && !out_done_q && out_x_end;
        out_tuser        = busy && !out_done_q && (out_x == '0) && (out_y == '0);
        err_tlast        = err_tlast_q;
        err_cfg          = err_cfg_q;
    end

endmodule : ac_frame_ctrl

// File: tb/tb_ac_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ac_frame_ctrl: self-checking bench for ac_frame_ctrl (CNT_W=16,
// SCALE_LOG2=2). Output framing is checked against a scoreboard of expected
// (tlast, tuser) pairs pushed when a frame is started and popped per out_fire.
// ---------------------------------------------------------------------------
module tb_ac_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [15:0] cfg_width;
    logic [15:0] cfg_height;
    logic        irq_clr;
    logic        in_en;
    logic        in_fire;
    logic        in_tlast;
    logic        out_fire;
    logic        out_tlast;
    logic        out_tuser;
    logic        busy;
    logic        interrupt_updone;
    logic        err_tlast;
    logic        err_cfg;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic tlast;
        logic tuser;
    } beat_t;

    beat_t sb_q[$];

    always #5 clk = ~clk;

    ac_frame_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_start        (cfg_start),
        .cfg_width        (cfg_width),
        .cfg_height       (cfg_height),
        .irq_clr          (irq_clr),
        .in_en            (in_en),
        .in_fire          (in_fire),
        .in_tlast         (in_tlast),
        .out_fire         (out_fire),
        .out_tlast        (out_tlast),
        .out_tuser        (out_tuser),
        .busy             (busy),
        .interrupt_updone (interrupt_updone),
        .err_tlast        (err_tlast),
        .err_cfg          (err_cfg)
    );

    // Expected output framing for a whole up-scaled w x h frame.
    task automatic push_frame(input int w, input int h);
        int    ow;
        int    n;
        beat_t b;
        ow = w * 4;
        n  = ow * h * 4;
        for (int k = 0; k < n; k++) begin
            b.tlast = ((k % ow) == (ow - 1));
            b.tuser = (k == 0);
            sb_q.push_back(b);
        end
    endtask

    task automatic pop_exp(output beat_t e);
        if (sb_q.size() == 0) begin
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_start = 1'b0; cfg_width = '0; cfg_height = '0;
        irq_clr = 1'b0; in_fire = 1'b0; in_tlast = 1'b0; out_fire = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, in_en, interrupt_updone, out_tlast, out_tuser, err_tlast, err_cfg} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=0000000",
                     {busy, in_en, interrupt_updone, out_tlast, out_tuser, err_tlast, err_cfg});
        end
    endtask

    task automatic test_basic();
        beat_t e;
        @(negedge clk); cfg_width = 16'd2; cfg_height = 16'd2; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_en !== 1'b1) begin
            failures++;
            $display("FAIL basic_start busy=%b in_en=%b expected 1 1", busy, in_en);
        end
        push_frame(2, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (in_en !== 1'b1) begin
                failures++;
                $display("FAIL basic_in_en beat=%0d got=%b expected=1", i, in_en);
            end
            in_fire = 1'b1; in_tlast = (i % 2 == 1);
        end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0) begin
                in_fire = 1'b0; in_tlast = 1'b0;
                checks++;
                if (in_en !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_in_en_drop got=%b expected=0", in_en);
                end
            end
            pop_exp(e);
            checks++;
            if (out_tlast !== e.tlast || out_tuser !== e.tuser) begin
                failures++;
                $display("FAIL basic_beat k=%0d tlast/tuser got=%b%b expected=%b%b",
                         k, out_tlast, out_tuser, e.tlast, e.tuser);
            end
            out_fire = 1'b1;
        end
        @(negedge clk); out_fire = 1'b0;
        checks++;
        if (interrupt_updone !== 1'b1 || busy !== 1'b0 || in_en !== 1'b0) begin
            failures++;
            $display("FAIL basic_done irq/busy/in_en got=%b%b%b expected=100",
                     interrupt_updone, busy, in_en);
        end
        checks++;
        if (err_tlast !== 1'b0) begin
            failures++;
            $display("FAIL basic_err_tlast got=%b expected=0", err_tlast);
        end
        @(negedge clk); irq_clr = 1'b1;
        @(negedge clk); irq_clr = 1'b0;
        checks++;
        if (interrupt_updone !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_irq_clr irq/busy got=%b%b expected=00", interrupt_updone, busy);
        end
    endtask

    task automatic test_same_cycle();
        beat_t e;
        @(negedge clk); cfg_width = 16'd2; cfg_height = 16'd2; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        push_frame(2, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_fire = 1'b1; in_tlast = (i % 2 == 1);
        end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0) begin
                in_fire = 1'b0; in_tlast = 1'b0;
            end
            pop_exp(e);
            checks++;
            if (out_tlast !== e.tlast || out_tuser !== e.tuser) begin
                failures++;
                $display("FAIL same_beat k=%0d tlast/tuser got=%b%b expected=%b%b",
                         k, out_tlast, out_tuser, e.tlast, e.tuser);
            end
            out_fire = 1'b1;
            if (k == 63) begin
                checks++;
                if (interrupt_updone !== 1'b0 || busy !== 1'b1 || in_en !== 1'b1) begin
                    failures++;
                    $display("FAIL same_pre irq/busy/in_en got=%b%b%b expected=011",
                             interrupt_updone, busy, in_en);
                end
                in_fire = 1'b1; in_tlast = 1'b1;
            end
        end
        @(negedge clk); out_fire = 1'b0; in_fire = 1'b0; in_tlast = 1'b0;
        checks++;
        if (interrupt_updone !== 1'b1 || busy !== 1'b0 || err_tlast !== 1'b0) begin
            failures++;
            $display("FAIL same_done irq/busy/err_tlast got=%b%b%b expected=100",
                     interrupt_updone, busy, err_tlast);
        end
        @(negedge clk); irq_clr = 1'b1;
        @(negedge clk); irq_clr = 1'b0;
    endtask

    task automatic test_cfg_err();
        @(negedge clk); cfg_width = 16'd0; cfg_height = 16'd2; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        checks++;
        if (err_cfg !== 1'b1 || busy !== 1'b0 || in_en !== 1'b0) begin
            failures++;
            $display("FAIL cfg_zero_w err_cfg/busy/in_en got=%b%b%b expected=100", err_cfg, busy, in_en);
        end
        @(negedge clk); cfg_width = 16'd3; cfg_height = 16'd0; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        checks++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cfg_zero_h err_cfg/busy got=%b%b expected=10", err_cfg, busy);
        end
        @(negedge clk); cfg_width = 16'd2; cfg_height = 16'd2; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        checks++;
        if (err_cfg !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cfg_valid err_cfg/busy got=%b%b expected=01", err_cfg, busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); cfg_width = 16'd2; cfg_height = 16'd2; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_fire = 1'b1; in_tlast = (i % 2 == 1);
        end
        @(negedge clk); in_fire = 1'b0; in_tlast = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_en !== 1'b0 || interrupt_updone !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid busy/in_en/irq got=%b%b%b expected=000", busy, in_en, interrupt_updone);
        end
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            out_fire = 1'b1;
            in_fire  = (k < 4);
        end
        @(negedge clk); out_fire = 1'b0; in_fire = 1'b0;
        checks++;
        if (busy !== 1'b0 || interrupt_updone !== 1'b0 || out_tuser !== 1'b0 || out_tlast !== 1'b0) begin
            failures++;
            $display("FAIL rst_ignore busy/irq/tuser/tlast got=%b%b%b%b expected=0000",
                     busy, interrupt_updone, out_tuser, out_tlast);
        end
    endtask

    task automatic test_tlast_err();
        beat_t e;
        @(negedge clk); cfg_width = 16'd4; cfg_height = 16'd1; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        push_frame(4, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1 || i == 2) begin
                checks++;
                if (err_tlast !== (i == 2)) begin
                    failures++;
                    $display("FAIL tlast_err_flag beat=%0d got=%b expected=%b", i, err_tlast, (i == 2));
                end
            end
            in_fire = 1'b1; in_tlast = (i == 1);
        end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0) begin
                in_fire = 1'b0; in_tlast = 1'b0;
            end
            pop_exp(e);
            checks++;
            if (out_tlast !== e.tlast || out_tuser !== e.tuser) begin
                failures++;
                $display("FAIL tlast_beat k=%0d tlast/tuser got=%b%b expected=%b%b",
                         k, out_tlast, out_tuser, e.tlast, e.tuser);
            end
            out_fire = 1'b1;
        end
        @(negedge clk); out_fire = 1'b0;
        checks++;
        if (interrupt_updone !== 1'b1 || err_tlast !== 1'b1) begin
            failures++;
            $display("FAIL tlast_done irq/err_tlast got=%b%b expected=11", interrupt_updone, err_tlast);
        end
    endtask

    task automatic test_back_to_back();
        beat_t e;
        // Still in DONE from the previous frame: start must be ignored.
        @(negedge clk); cfg_width = 16'd1; cfg_height = 16'd1; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        checks++;
        if (interrupt_updone !== 1'b1 || busy !== 1'b0 || err_tlast !== 1'b1) begin
            failures++;
            $display("FAIL b2b_start_ignored irq/busy/err_tlast got=%b%b%b expected=101",
                     interrupt_updone, busy, err_tlast);
        end
        @(negedge clk); irq_clr = 1'b1;
        @(negedge clk); irq_clr = 1'b0;
        checks++;
        if (interrupt_updone !== 1'b0 || busy !== 1'b0 || in_en !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle irq/busy/in_en got=%b%b%b expected=000", interrupt_updone, busy, in_en);
        end
        @(negedge clk); cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_en !== 1'b1 || err_tlast !== 1'b0) begin
            failures++;
            $display("FAIL b2b_run busy/in_en/err_tlast got=%b%b%b expected=110", busy, in_en, err_tlast);
        end
        push_frame(1, 1);
        @(negedge clk); in_fire = 1'b1; in_tlast = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                in_fire = 1'b0; in_tlast = 1'b0;
            end
            pop_exp(e);
            checks++;
            if (out_tlast !== e.tlast || out_tuser !== e.tuser) begin
                failures++;
                $display("FAIL b2b_beat k=%0d tlast/tuser got=%b%b expected=%b%b",
                         k, out_tlast, out_tuser, e.tlast, e.tuser);
            end
            out_fire = 1'b1;
        end
        @(negedge clk); out_fire = 1'b0;
        checks++;
        if (interrupt_updone !== 1'b1 || err_tlast !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done irq/err_tlast/busy got=%b%b%b expected=100",
                     interrupt_updone, err_tlast, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_cfg_err();
        test_reset_mid();
        test_tlast_err();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_ac_frame_ctrl

// File: doc/ac_frame_ctrl.md
Name: ac_frame_ctrl

Overview:
- Frame sequencer between the access-control stream ports and the up-sampling core.
- Latches the source frame geometry on a start command and gates input-beat acceptance.
- Counts accepted input and produced output beats, and generates output tlast/tuser framing.
- Raises a done interrupt once the full up-scaled frame has left, and flags framing errors.

Parameters:
- CNT_W, 16: width of source width/height fields and input counters.
- SCALE_LOG2, 2: log2 of the up-scale factor per axis (2 gives 4x); output counters are CNT_W+SCALE_LOG2 bits.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- cfg_start, in, 1: start pulse from the config register file.
- cfg_width, in, CNT_W: source pixels per line.
- cfg_height, in, CNT_W: source lines per frame.
- irq_clr, in, 1: clears interrupt_updone.
- in_en, out, 1: permits input handshake; the stream slave gates tready with it.
- in_fire, in, 1: input beat accepted (tvalid & tready & in_en).
- in_tlast, in, 1: tlast of the accepted input beat.
- out_fire, in, 1: output beat accepted on the stream master.
- out_tlast, out, 1: current output beat is last of its output line.
- out_tuser, out, 1: current output beat is first of the frame.
- busy, out, 1: frame in progress.
- interrupt_updone, out, 1: frame complete, level until cleared.
- err_tlast, out, 1: sticky, input tlast mismatch.
- err_cfg, out, 1: sticky, start issued with zero geometry.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters and flags 0. Reset mid-frame abandons the frame; there is no done interrupt for it.
- State IDLE:
  - cfg_start with width!=0 and height!=0: latch W, H; clear in_x, in_y, out_x, out_y, in_done, out_done; go to RUN.
  - cfg_start with width==0 or height==0: stay in IDLE, set err_cfg.
- State RUN:
  - busy=1.
  - in_en = !in_done; de-asserts combinationally the cycle after the last input beat is registered.
  - Input counter: in_fire increments in_x. Wrap at W-1 to 0 and increment in_y. Beat at (W-1, H-1) sets in_done.
  - Output counter: out_fire increments out_x. Wrap at (W<<SCALE_LOG2)-1 to 0 and increment out_y. Beat at ((W<<S)-1, (H<<S)-1) sets out_done.
  - When in_done and out_done are both set (including both set in the same cycle): go to DONE.
- State DONE:
  - busy=0, in_en=0, interrupt_updone=1.
  - irq_clr: interrupt_updone goes to 0, state goes to IDLE next cycle.
  - cfg_start is ignored in DONE and in RUN; no queuing.
- Timing: cfg_start at cycle N gives busy=1 and in_en=1 at N+1. Last out_fire at cycle M (in_done already set) gives interrupt_updone=1 at M+1.
- out_tlast = RUN & !out_done & (out_x == (W<<S)-1). Combinational.
- out_tuser = RUN & !out_done & out_x==0 & out_y==0. Combinational.
- in_tlast mismatch sets err_tlast:
  - in_tlast=1 with in_x != W-1, or
  - in_tlast=0 with in_x == W-1.
  - Counters stay authoritative and are not resynchronised to tlast.
- Beats outside RUN, or after in_done/out_done, are ignored; counters hold.
- Errors: err_tlast and err_cfg are cleared only by rst or by an accepted cfg_start.
- Arithmetic: (W<<S) is computed in CNT_W+SCALE_LOG2 bits, so there is no overflow at maximum W.

Decomposition:
- Shared package ac_pkg:
  - state enum {IDLE, RUN, DONE}.
  - default CNT_W / SCALE_LOG2 constants.
- One natural sub-module, ac_xy_counter: parameterised 2-D wrap counter (width, x_max, y_max, inc, clr → x, y, x_end, last). Instantiated twice: input and output.

Test Plan:
- W=2, H=2, S=2; 4 in_fire with tlast on beats 2 and 4; 64 out_fire:
  - out_tlast on beats 8, 16, …, 64; out_tuser on beat 1 only.
  - in_en drops after beat 4; interrupt_updone=1 one cycle after beat 64.
  - err_tlast=0.
- Same frame, last in_fire and last out_fire in the same cycle → DONE next cycle, interrupt_updone=1.
- cfg_start with cfg_width=0 → stays IDLE, err_cfg=1, busy=0. Then a valid start → err_cfg=0, busy=1.
- W=4, H=1; in_tlast on beat 2 → err_tlast=1; frame still completes after 4 in / 64 out.
- rst asserted after 3 in_fire → next cycle busy=0, in_en=0, interrupt_updone=0. Later out_fire is ignored.
- DONE with cfg_start pulsed, then irq_clr → start ignored, IDLE next cycle. A following cfg_start → RUN.
